// File: rtl/reg8_a.sv
// 8-bit load-enable register built from identical bit slices.
// Each slice: enable mux, synchronous reset, rising-edge flop.
module reg8_a #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic [WIDTH-1:0] Reg_In,
  output logic [WIDTH-1:0] Reg_Out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic mux_out;

    // Recirculate the stored bit when not loading, so hold needs no clock gating.
    assign mux_out = EN ? Reg_In[i] : Reg_Out[i];

    always_ff @(posedge clk) begin
      if (res) begin
        Reg_Out[i] <= 1'b0;
      end else begin
        Reg_Out[i] <= mux_out;
      end
    end
  end

endmodule

// File: tb/tb_reg8_a.sv
// Directed bench for reg8_a: a value-level model feeds an expected queue that is
// checked every cycle after the first reset edge, plus literal spot checks.
module tb_reg8_a;
  localparam int W = 8;

  logic         clk;
  logic         res;
  logic         en;
  logic [W-1:0] reg_in;
  logic [W-1:0] reg_out;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_val;
  logic         model_live = 1'b0;

  reg8_a #(.WIDTH(W)) dut (
    .clk    (clk),
    .res    (res),
    .EN     (en),
    .Reg_In (reg_in),
    .Reg_Out(reg_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register semantics at the value level: clear, load, or keep.
  function automatic logic [W-1:0] next_val(input logic r, input logic e,
                                            input logic [W-1:0] d,
                                            input logic [W-1:0] cur);
    if (r) return '0;
    if (e) return d;
    return cur;
  endfunction

  always @(posedge clk) begin
    if (res || model_live) begin
      model_live <= 1'b1;
      model_val  <= next_val(res, en, reg_in, model_val);
      exp_q.push_back(next_val(res, en, reg_in, model_val));
    end
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("model", reg_out, exp_q.pop_front());
    end
  end

  // Driver: apply inputs at the falling edge, return just after the next rising edge.
  task automatic cycle(input logic r, input logic e, input logic [W-1:0] d);
    @(negedge clk);
    res    = r;
    en     = e;
    reg_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] walk;
    res    = 1'b0;
    en     = 1'b0;
    reg_in = '0;

    // Reset state
    cycle(1'b1, 1'b0, 8'h00);
    check("reset", reg_out, 8'h00);

    // Load then hold for three edges
    cycle(1'b0, 1'b1, 8'h77);
    check("load_77", reg_out, 8'h77);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check("hold_77", reg_out, 8'h77);
    end

    // Reset beats enable, and stays in force while held
    cycle(1'b1, 1'b1, 8'hA5);
    check("rst_prio", reg_out, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 8'hA5);
      check("rst_held", reg_out, 8'h00);
    end

    // Release: load on the very first edge after reset drops
    cycle(1'b0, 1'b1, 8'h5A);
    check("rst_release", reg_out, 8'h5A);

    // Mid-cycle data change: only the value at the edge is captured
    @(negedge clk);
    res    = 1'b0;
    en     = 1'b1;
    reg_in = 8'h3C;
    #2;
    check("mid_no_change", reg_out, 8'h5A);
    reg_in = 8'hFF;
    @(posedge clk);
    #1;
    check("mid_edge_ff", reg_out, 8'hFF);

    // Reset pulse between edges has no effect
    @(negedge clk);
    en  = 1'b0;
    res = 1'b1;
    #2;
    check("pulse_mid", reg_out, 8'hFF);
    res = 1'b0;
    @(posedge clk);
    #1;
    check("pulse_sync", reg_out, 8'hFF);

    // Walking one
    walk = 8'h01;
    for (int i = 0; i < W; i++) begin
      cycle(1'b0, 1'b1, walk);
      check("walk", reg_out, walk);
      walk = walk << 1;
    end

    // All-ones to all-zeros and long hold
    cycle(1'b0, 1'b1, 8'hFF);
    check("load_ff", reg_out, 8'hFF);
    cycle(1'b0, 1'b1, 8'h00);
    check("load_00", reg_out, 8'h00);
    cycle(1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 8'h3C);
    end
    check("long_hold", reg_out, 8'hC3);

    // Let the last queued expectation drain
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
